// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the NoC node endpoints: type encodings, per-VC
// framing states and field-extraction helpers parameterized by the mesh field width R.
package noc_flit_pkg;

  localparam int MSG_BITS = 12;
  localparam int FLIT_MAX = 64;

  localparam logic [1:0] ID_ILLEGAL = 2'b00;
  localparam logic [1:0] ID_HEAD    = 2'b01;
  localparam logic [1:0] ID_BODY    = 2'b10;
  localparam logic [1:0] ID_TAIL    = 2'b11;

  typedef enum logic [1:0] {
    ILLEGAL = ID_ILLEGAL,
    HEAD    = ID_HEAD,
    BODY    = ID_BODY,
    TAIL    = ID_TAIL
  } flit_type_e;

  typedef enum logic {
    IDLE,
    IN_PKT
  } vc_state_e;

  // Flits of any width up to FLIT_MAX are zero-extended into this container.
  typedef logic [FLIT_MAX-1:0] flit_word_t;

  function automatic int isqrt(input int n);
    int s;
    s = 0;
    for (int i = 0; i <= n; i++) begin
      if (i * i <= n) s = i;
    end
    return s;
  endfunction

  function automatic logic [31:0] get_field(input flit_word_t f, input int lsb, input int r);
    flit_word_t mask;
    mask = (flit_word_t'(1) << r) - flit_word_t'(1);
    return 32'((f >> lsb) & mask);
  endfunction

  function automatic flit_type_e get_type(input flit_word_t f, input int dw, input int id_bits);
    return flit_type_e'(2'(f >> (dw - id_bits)));
  endfunction

  // Node index is row-major: DIM*Y + X.
  function automatic logic [31:0] get_src(input flit_word_t f, input int r, input int dim);
    return 32'(dim) * get_field(f, 2 * r, r) + get_field(f, 3 * r, r);
  endfunction

  function automatic logic [31:0] get_dst(input flit_word_t f, input int r, input int dim);
    return 32'(dim) * get_field(f, r, r) + get_field(f, 0, r);
  endfunction

  function automatic logic [MSG_BITS-1:0] get_msg(input flit_word_t f, input int r);
    return MSG_BITS'(f >> (4 * r));
  endfunction

endpackage

// File: rtl/sink_desc_fifo.sv
// Generic synchronous first-word-fall-through FIFO with registered full/empty flags.
module sink_desc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push  = push & !full_q;
  assign do_pop   = pop & !empty_q;
  assign pop_data = mem[rd_ptr];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

  always_comb begin
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW + 1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: storage is deliberately not reset; empty_q guards every read of stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/node_packet_sink.sv
// NoC ejection endpoint: per-VC head/body/tail framing, packet/flit/error counters and a
// descriptor queue. Define SINK_DEST_CHECK_EN to reject heads not addressed to NODE_ID.
module node_packet_sink
  import noc_flit_pkg::*;
#(
  parameter int N                = 16,
  parameter int NODE_ID          = 0,
  parameter int DATA_WIDTH       = 32,
  parameter int VC               = 4,
  parameter int IDENTIFIER_BITS  = 2,
  parameter int FLITS_PER_PACKET = 16,
  parameter int DESC_DEPTH       = 8,
  parameter int CYCLE_WIDTH      = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH-1:0]               data_in,
  input  logic                                valid_in,
  output logic                                ready_in,
  input  logic [$clog2(VC)-1:0]               vc_sel,
  output logic                                desc_valid,
  input  logic                                desc_ready,
  output logic [$clog2(VC)-1:0]               desc_vc,
  output logic [$clog2(N)-1:0]                desc_src,
  output logic [MSG_BITS-1:0]                 desc_msg,
  output logic [$clog2(FLITS_PER_PACKET):0]   desc_len,
  output logic [CYCLE_WIDTH-1:0]              desc_time,
  output logic [31:0]                         pkt_count,
  output logic [31:0]                         flit_count,
  output logic [31:0]                         err_count,
  output logic [VC-1:0]                       err_vc
);

  localparam int DIM  = isqrt(N);
  localparam int R    = $clog2(DIM);
  localparam int VCW  = $clog2(VC);
  localparam int SRCW = $clog2(N);
  localparam int LENW = $clog2(FLITS_PER_PACKET) + 1;

  typedef struct packed {
    logic [VCW-1:0]         vc;
    logic [SRCW-1:0]        src;
    logic [MSG_BITS-1:0]    msg;
    logic [LENW-1:0]        len;
    logic [CYCLE_WIDTH-1:0] stamp;
  } desc_t;

  vc_state_e             state_q [VC];
  vc_state_e             state_d [VC];
  logic [LENW-1:0]       len_q   [VC];
  logic [LENW-1:0]       len_d   [VC];
  logic [SRCW-1:0]       src_q   [VC];
  logic [SRCW-1:0]       src_d   [VC];
  logic [MSG_BITS-1:0]   msg_q   [VC];
  logic [MSG_BITS-1:0]   msg_d   [VC];

  flit_type_e            ftype;
  logic [SRCW-1:0]       flit_src;
  logic [MSG_BITS-1:0]   flit_msg;
  logic                  dest_ok;
  logic                  accept, push, err;
  logic                  fifo_full, fifo_empty;
  logic [CYCLE_WIDTH-1:0] cycle_cnt;
  desc_t                 push_desc, pop_desc;

  assign ready_in = !fifo_full;
  assign accept   = valid_in & ready_in;

  assign ftype    = get_type(flit_word_t'(data_in), DATA_WIDTH, IDENTIFIER_BITS);
  assign flit_src = SRCW'(get_src(flit_word_t'(data_in), R, DIM));
  assign flit_msg = get_msg(flit_word_t'(data_in), R);

`ifdef SINK_DEST_CHECK_EN
  assign dest_ok = (get_dst(flit_word_t'(data_in), R, DIM) == 32'(NODE_ID));
`else
  assign dest_ok = 1'b1;
`endif

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    src_d   = src_q;
    msg_d   = msg_q;
    push    = 1'b0;
    err     = 1'b0;
    if (accept) begin
      case (ftype)
        HEAD: begin
          if (!dest_ok) begin
            err              = 1'b1;
            state_d[vc_sel]  = IDLE;
          end else begin
            // A head inside a packet abandons the old one and restarts framing.
            err              = (state_q[vc_sel] == IN_PKT);
            state_d[vc_sel]  = IN_PKT;
            len_d[vc_sel]    = LENW'(1);
            src_d[vc_sel]    = flit_src;
            msg_d[vc_sel]    = flit_msg;
          end
        end
        BODY: begin
          if (state_q[vc_sel] == IDLE) begin
            err = 1'b1;
          end else if (len_q[vc_sel] == LENW'(FLITS_PER_PACKET)) begin
            err             = 1'b1;
            state_d[vc_sel] = IDLE;
          end else begin
            len_d[vc_sel]   = len_q[vc_sel] + LENW'(1);
          end
        end
        TAIL: begin
          if (state_q[vc_sel] == IDLE) begin
            err = 1'b1;
          end else if (len_q[vc_sel] == LENW'(FLITS_PER_PACKET)) begin
            err             = 1'b1;
            state_d[vc_sel] = IDLE;
          end else begin
            push            = 1'b1;
            state_d[vc_sel] = IDLE;
          end
        end
        default: err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VC; i++) begin
        state_q[i] <= IDLE;
        len_q[i]   <= '0;
        src_q[i]   <= '0;
        msg_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      src_q   <= src_d;
      msg_q   <= msg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt  <= '0;
      pkt_count  <= '0;
      flit_count <= '0;
      err_count  <= '0;
      err_vc     <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (push)   pkt_count  <= pkt_count + 32'd1;
      if (accept) flit_count <= flit_count + 32'd1;
      if (err) begin
        err_count      <= err_count + 32'd1;
        err_vc[vc_sel] <= 1'b1;
      end
    end
  end

  assign push_desc = '{
    vc:    vc_sel,
    src:   src_q[vc_sel],
    msg:   msg_q[vc_sel],
    len:   len_q[vc_sel] + LENW'(1),
    stamp: cycle_cnt
  };

  sink_desc_fifo #(
    .WIDTH ($bits(desc_t)),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_desc),
    .pop       (desc_ready),
    .pop_data  (pop_desc),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     ()
  );

  assign desc_valid = !fifo_empty;
  assign desc_vc    = pop_desc.vc;
  assign desc_src   = pop_desc.src;
  assign desc_msg   = pop_desc.msg;
  assign desc_len   = pop_desc.len;
  assign desc_time  = pop_desc.stamp;

endmodule
